// File: rtl/accel_frame_assembler.sv
// accel_frame_assembler: packs an MPU-6050 burst-read byte stream into seven signed 16-bit words
module accel_frame_assembler #(
    parameter int FRAME_BYTES = 14,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic [15:0] temp_raw,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        frame_err,
    output logic [1:0]  frame_err_code,
    output logic [7:0]  overrun_cnt,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t        state, state_nx;
    logic [3:0]    byte_idx, byte_idx_nx, cur_idx;
    logic [CW-1:0] idle_cnt, idle_cnt_nx;
    logic [7:0]    staging [14];
    logic [7:0]    frame   [14];
    logic          take, done, err;
    logic [1:0]    err_code;

    assign busy = (state != IDLE);

    // next state, byte position, inter-byte timer and frame outcome for this cycle
    always_comb begin
        state_nx    = state;
        byte_idx_nx = byte_idx;
        idle_cnt_nx = idle_cnt;
        cur_idx     = frame_start ? 4'd0 : byte_idx;
        take        = byte_valid && (frame_start || state == COLLECT);
        done        = 1'b0;
        err         = 1'b0;
        err_code    = 2'd0;
        if (frame_start) begin
            state_nx    = COLLECT;
            byte_idx_nx = 4'd0;
            idle_cnt_nx = '0;
            if (state == COLLECT) begin
                err      = 1'b1;
                err_code = 2'd1;
            end
        end else if (state == COLLECT && !byte_valid) begin
            if (idle_cnt == CW'(TIMEOUT_CYC - 1)) begin
                err      = 1'b1;
                err_code = 2'd3;
                state_nx = IDLE;
            end else begin
                idle_cnt_nx = idle_cnt + CW'(1);
            end
        end else if (state == DRAIN && byte_valid && byte_last) begin
            state_nx = IDLE;
        end
        if (take) begin
            idle_cnt_nx = '0;
            byte_idx_nx = cur_idx + 4'd1;
            if (cur_idx == 4'(FRAME_BYTES - 1)) begin
                if (byte_last) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    err      = 1'b1;
                    err_code = 2'd2;
                    state_nx = DRAIN;
                end
            end else if (byte_last) begin
                err      = 1'b1;
                err_code = 2'd1;
                state_nx = IDLE;
            end
        end
    end

    // staged bytes with the byte arriving this cycle merged in, so completion loads without delay
    always_comb begin
        for (int i = 0; i < 14; i++) begin
            frame[i] = (i >= FRAME_BYTES) ? 8'h00 :
                       (take && cur_idx == 4'(i)) ? byte_data : staging[i];
        end
    end

    // FSM state, byte index, timeout counter and staging buffer
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            byte_idx <= 4'd0;
            idle_cnt <= '0;
            for (int i = 0; i < 14; i++) staging[i] <= 8'h00;
        end else begin
            state    <= state_nx;
            byte_idx <= byte_idx_nx;
            idle_cnt <= idle_cnt_nx;
            if (take) staging[cur_idx] <= byte_data;
        end
    end

    // output sample register, valid/ready handshake, overrun counter and error reporting
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sample_valid   <= 1'b0;
            accel_x        <= 16'h0;
            accel_y        <= 16'h0;
            accel_z        <= 16'h0;
            temp_raw       <= 16'h0;
            gyro_x         <= 16'h0;
            gyro_y         <= 16'h0;
            gyro_z         <= 16'h0;
            frame_err      <= 1'b0;
            frame_err_code <= 2'd0;
            overrun_cnt    <= 8'h0;
        end else begin
            frame_err <= err;
            if (err) frame_err_code <= err_code;
            if (done && (!sample_valid || sample_ready)) begin
                sample_valid <= 1'b1;
                accel_x      <= {frame[0],  frame[1]};
                accel_y      <= {frame[2],  frame[3]};
                accel_z      <= {frame[4],  frame[5]};
                temp_raw     <= {frame[6],  frame[7]};
                gyro_x       <= {frame[8],  frame[9]};
                gyro_y       <= {frame[10], frame[11]};
                gyro_z       <= {frame[12], frame[13]};
            end else if (done) begin
                if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_accel_frame_assembler.sv
// tb_accel_frame_assembler: directed stimulus checked against a queue-based frame model every cycle
module tb_accel_frame_assembler;
    localparam int FB = 14;
    localparam int TO = 4000;

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic        sample_ready = 1'b0;
    logic        sample_valid;
    logic [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;
    logic        frame_err;
    logic [1:0]  frame_err_code;
    logic [7:0]  overrun_cnt;
    logic        busy;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    accel_frame_assembler #(.FRAME_BYTES(FB), .TIMEOUT_CYC(TO)) dut (
        .clk_in(clk_in), .reset(reset), .frame_start(frame_start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp_raw(temp_raw),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .frame_err(frame_err), .frame_err_code(frame_err_code),
        .overrun_cnt(overrun_cnt), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    // model: the open frame is a byte queue, the gap is counted in idle cycles
    int          mode;
    int          gap;
    logic [7:0]  q[$];
    logic        m_valid, m_err;
    logic [1:0]  m_code;
    logic [7:0]  m_ovr;
    logic [15:0] m_w [7];

    always @(posedge clk_in) begin
        logic       pv;
        logic       fin;
        logic [1:0] e;
        pv  = m_valid;
        fin = 1'b0;
        e   = 2'd0;
        if (reset) begin
            mode = 0;
            gap = 0;
            q.delete();
            m_valid = 1'b0;
            m_err = 1'b0;
            m_code = 2'd0;
            m_ovr = 8'd0;
            for (int k = 0; k < 7; k++) m_w[k] = 16'h0;
        end else begin
            if (frame_start) begin
                if (mode == 1) e = 2'd1;
                mode = 1;
                gap = 0;
                q.delete();
            end
            if (byte_valid && mode == 1) begin
                q.push_back(byte_data);
                gap = 0;
                if (q.size() == FB) begin
                    if (byte_last) begin fin = 1'b1; mode = 0; end
                    else begin e = 2'd2; mode = 2; end
                end else if (byte_last) begin
                    e = 2'd1;
                    mode = 0;
                end
            end else if (byte_valid && mode == 2 && byte_last) begin
                mode = 0;
            end else if (!byte_valid && mode == 1 && !frame_start) begin
                gap++;
                if (gap >= TO) begin e = 2'd3; mode = 0; end
            end
            m_err = (e != 2'd0);
            if (m_err) m_code = e;
            if (fin) begin
                if (!pv || sample_ready) begin
                    m_valid = 1'b1;
                    for (int k = 0; k < 7; k++) m_w[k] = {q[2*k], q[2*k+1]};
                end else if (m_ovr != 8'hFF) begin
                    m_ovr = m_ovr + 8'd1;
                end
            end else if (pv && sample_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clk_in) begin
        logic [124:0] a, x;
        if (chk_en) begin
            a = {sample_valid, accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z,
                 frame_err, frame_err_code, overrun_cnt, busy};
            x = {m_valid, m_w[0], m_w[1], m_w[2], m_w[3], m_w[4], m_w[5], m_w[6],
                 m_err, m_code, m_ovr, (mode != 0)};
            total++;
            if (a !== x) begin
                bad++;
                $display("FAIL cycle_model t=%0t dut=%h model=%h", $time, a, x);
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic fs, input logic bv, input logic [7:0] d,
                       input logic bl, input logic rdy);
        frame_start  = fs;
        byte_valid   = bv;
        byte_data    = d;
        byte_last    = bl;
        sample_ready = rdy;
        @(posedge clk_in);
        #1;
    endtask

    task automatic frame(input logic [7:0] base, input int n, input logic with_last,
                         input logic rdy);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, rdy);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b1, base + 8'(i), with_last && (i == n - 1), rdy);
    endtask

    initial begin
        cyc(0, 0, 8'h00, 0, 0);
        chk_en = 1'b1;
        cyc(0, 0, 8'h00, 0, 0);
        chk("rst_valid", {15'd0, sample_valid}, 16'h0);
        chk("rst_ovr", {8'd0, overrun_cnt}, 16'h0);
        chk("rst_busy", {15'd0, busy}, 16'h0);
        reset = 1'b0;
        cyc(0, 0, 8'h00, 0, 0);

        // basic frame 0x01..0x0E
        frame(8'h01, 14, 1, 0);
        chk("t1_valid", {15'd0, sample_valid}, 16'h1);
        chk("t1_ax", accel_x, 16'h0102);
        chk("t1_gz", gyro_z, 16'h0D0E);
        chk("t1_err", {15'd0, frame_err}, 16'h0);
        chk("model_ax", m_w[0], 16'h0102);
        chk("model_temp", m_w[3], 16'h0708);

        // overrun while held
        cyc(0, 0, 8'h00, 0, 1);
        chk("t2_clear", {15'd0, sample_valid}, 16'h0);
        frame(8'h21, 14, 1, 0);
        frame(8'h41, 14, 1, 0);
        chk("t2_ax_kept", accel_x, 16'h2122);
        chk("t2_ovr", {8'd0, overrun_cnt}, 16'h1);
        cyc(0, 0, 8'h00, 0, 1);
        chk("t2_hs", {15'd0, sample_valid}, 16'h0);

        // short and long frames
        frame(8'h51, 6, 1, 0);
        chk("t3_short_err", {15'd0, frame_err}, 16'h1);
        chk("t3_short_code", {14'd0, frame_err_code}, 16'h1);
        chk("t3_valid0", {15'd0, sample_valid}, 16'h0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("t3_pulse", {15'd0, frame_err}, 16'h0);
        frame(8'h61, 14, 0, 0);
        chk("t3_long_code", {14'd0, frame_err_code}, 16'h2);
        chk("t3_drain_busy", {15'd0, busy}, 16'h1);
        cyc(0, 1, 8'h55, 0, 0);
        cyc(0, 1, 8'h56, 0, 0);
        chk("t3_drain_noerr", {15'd0, frame_err}, 16'h0);
        cyc(0, 1, 8'h66, 1, 0);
        chk("t3_drain_done", {15'd0, busy}, 16'h0);

        // timeout after byte 3
        frame(8'h71, 4, 0, 0);
        repeat (TO - 1) cyc(0, 0, 8'h00, 0, 0);
        chk("t4_no_early", {15'd0, frame_err}, 16'h0);
        cyc(0, 0, 8'h00, 0, 0);
        chk("t4_err", {15'd0, frame_err}, 16'h1);
        chk("t4_code", {14'd0, frame_err_code}, 16'h3);
        chk("t4_busy", {15'd0, busy}, 16'h0);

        // restart inside a frame, then complete the restarted frame
        frame(8'h91, 3, 0, 0);
        cyc(1, 0, 8'h00, 0, 0);
        chk("t4b_restart_code", {14'd0, frame_err_code}, 16'h1);
        chk("t4b_busy", {15'd0, busy}, 16'h1);
        for (int i = 0; i < 14; i++) cyc(0, 1, 8'h81 + 8'(i), i == 13, 0);
        chk("t4b_ax", accel_x, 16'h8182);

        // completion coincident with handshake
        cyc(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 14; i++) cyc(0, 1, 8'hA1 + 8'(i), i == 13, i == 13);
        chk("t5_valid", {15'd0, sample_valid}, 16'h1);
        chk("t5_ax", accel_x, 16'hA1A2);
        chk("t5_gz", gyro_z, 16'hADAE);
        chk("t5_ovr", {8'd0, overrun_cnt}, 16'h1);
        cyc(0, 0, 8'h00, 0, 1);

        // reset mid-frame drops everything
        frame(8'hC1, 14, 1, 0);
        frame(8'hD1, 8, 0, 0);
        reset = 1'b1;
        cyc(0, 1, 8'h99, 0, 0);
        cyc(0, 1, 8'h9A, 0, 0);
        chk("t6_rst_valid", {15'd0, sample_valid}, 16'h0);
        chk("t6_rst_ax", accel_x, 16'h0);
        chk("t6_rst_ovr", {8'd0, overrun_cnt}, 16'h0);
        chk("t6_rst_code", {14'd0, frame_err_code}, 16'h0);
        reset = 1'b0;
        frame(8'h11, 14, 1, 0);
        chk("t6_ax", accel_x, 16'h1112);
        chk("t6_temp", temp_raw, 16'h1718);
        chk("t6_gz", gyro_z, 16'h1D1E);

        // overrun counter saturation
        repeat (256) frame(8'h30, 14, 1, 0);
        chk("t7_sat", {8'd0, overrun_cnt}, 16'h00FF);
        chk("t7_ax_kept", accel_x, 16'h1112);

        cyc(0, 0, 8'h00, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
